// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rx channel controller and its helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  localparam int DIV_MIN          = 4;
  localparam int UART_DEFAULT_DIV = 16;

  // Frame-format fields that travel together from pending to active.
  typedef struct packed {
    logic       enable;
    logic       lsb_first;
    logic [1:0] parity_type;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{enable: 1'b0, lsb_first: 1'b1, parity_type: PARITY_NONE};

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full  = (count == LEVEL_FULL);
  assign empty = (count == '0);
  assign level = count;
  assign pop   = rd_en & ~empty;
  assign push  = wr_en & (~full | rd_en);

  // Head is forced to zero when empty so the output is defined without resetting storage.
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: storage is not reset; only pointers and count carry state that matters after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for one uart_rx channel: shadowed config, centred bit-sample
// enable, and a receive FIFO with overrun/drop status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr,
  input  logic [DIV_WIDTH-1:0] cfg_divisor_in,
  input  logic                 cfg_lsb_first_in,
  input  logic [1:0]           cfg_parity_type_in,
  input  logic                 cfg_enable_in,
  output logic                 cfg_busy,
  output logic                 ce_rx,
  output logic                 cfg_lsb_first,
  output logic [1:0]           cfg_parity_type,
  output logic                 cfg_channel_enable,
  input  logic                 is_receiving,
  input  logic                 received,
  input  logic [7:0]           rx_byte,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic [7:0]           drop_cnt
);

  localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

  cfg_t                 cfg_in;
  cfg_t                 pend_cfg;
  cfg_t                 act_cfg;
  logic [DIV_WIDTH-1:0] div_in;
  logic [DIV_WIDTH-1:0] pend_div;
  logic [DIV_WIDTH-1:0] act_div;
  logic [DIV_WIDTH-1:0] div_next;
  logic                 pend_flag;
  logic                 apply;

  // ---------------------------------------------------------------- config shadow
  assign cfg_in = '{enable: cfg_enable_in, lsb_first: cfg_lsb_first_in,
                    parity_type: cfg_parity_type_in};
  assign div_in = (cfg_divisor_in < DIV_FLOOR) ? DIV_FLOOR : cfg_divisor_in;

  assign apply    = pend_flag & ~is_receiving;
  assign div_next = apply ? pend_div : act_div;
  // Busy only matters while a frame blocks the apply; an idle write lands next edge.
  assign cfg_busy = pend_flag & is_receiving;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cfg  <= CFG_RESET;
      pend_div  <= DIV_RESET;
      pend_flag <= 1'b0;
      act_cfg   <= CFG_RESET;
      act_div   <= DIV_RESET;
    end else begin
      if (cfg_wr) begin
        pend_cfg  <= cfg_in;
        pend_div  <= div_in;
        pend_flag <= 1'b1;
      end else if (apply) begin
        pend_flag <= 1'b0;
      end
      if (apply) begin
        act_cfg <= pend_cfg;
        act_div <= pend_div;
      end
    end
  end

  assign cfg_channel_enable = act_cfg.enable;
  assign cfg_lsb_first      = act_cfg.lsb_first;
  assign cfg_parity_type    = act_cfg.parity_type;

  // ---------------------------------------------------------------- baud counter
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] tgt;
  logic                 ce_q;

  // Idle preload uses the divisor that will be active on the next edge, so a frame
  // starting right after an apply is already centred on the new bit time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tgt  <= DIV_RESET >> 1;
      ce_q <= 1'b0;
    end else if (!is_receiving) begin
      cnt  <= '0;
      tgt  <= div_next >> 1;
      ce_q <= 1'b0;
    end else if (cnt == tgt - DIV_ONE) begin
      cnt  <= '0;
      tgt  <= act_div;
      ce_q <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_ONE;
      ce_q <= 1'b0;
    end
  end

  // Gating kills a pulse that would land in the cycle the frame ends.
  assign ce_rx = ce_q & is_receiving;

  // ---------------------------------------------------------------- receive FIFO
  logic fifo_full;
  logic fifo_empty;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (received),
    .wr_data (rx_byte),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign rd_valid = ~fifo_empty;

  // ---------------------------------------------------------------- overrun status
  logic drop;

  assign drop = received & fifo_full & ~rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overrun  <= 1'b1;
      drop_cnt <= ovr_clr ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
    end else if (ovr_clr) begin
      overrun  <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: sample-pulse timing from bit-time arithmetic,
// config shadowing, and a queue model of the receive FIFO and its status.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_divisor_in = '0;
  logic        cfg_lsb_first_in = 1'b0;
  logic [1:0]  cfg_parity_type_in = '0;
  logic        cfg_enable_in = 1'b0;
  logic        cfg_busy;
  logic        ce_rx;
  logic        cfg_lsb_first;
  logic [1:0]  cfg_parity_type;
  logic        cfg_channel_enable;
  logic        is_receiving = 1'b0;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic        ovr_clr = 1'b0;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  uart_rx_ctrl #(
    .DIV_WIDTH(16), .DEFAULT_DIV(16), .FIFO_DEPTH(8), .FIFO_AW(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_divisor_in(cfg_divisor_in),
    .cfg_lsb_first_in(cfg_lsb_first_in), .cfg_parity_type_in(cfg_parity_type_in),
    .cfg_enable_in(cfg_enable_in), .cfg_busy(cfg_busy), .ce_rx(ce_rx),
    .cfg_lsb_first(cfg_lsb_first), .cfg_parity_type(cfg_parity_type),
    .cfg_channel_enable(cfg_channel_enable), .is_receiving(is_receiving),
    .received(received), .rx_byte(rx_byte), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_level(fifo_level), .overrun(overrun),
    .ovr_clr(ovr_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Sample pulse k cycles into a frame: first at half a bit, then every full bit.
  function automatic bit ce_expected(input int k, input int div);
    int half;
    half = div / 2;
    if (k < half) return 1'b0;
    return ((k - half) % div) == 0;
  endfunction

  task automatic clear_inputs();
    cfg_wr   = 1'b0;
    received = 1'b0;
    rd_en    = 1'b0;
    ovr_clr  = 1'b0;
  endtask

  task automatic write_cfg(input int div, input bit lsb, input logic [1:0] par, input bit en);
    cfg_wr             = 1'b1;
    cfg_divisor_in     = 16'(div);
    cfg_lsb_first_in   = lsb;
    cfg_parity_type_in = par;
    cfg_enable_in      = en;
  endtask

  localparam logic [27:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0};

  task automatic test_reset();
    logic [27:0] got;
    int pulses;
    pulses = 0;
    clear_inputs();
    is_receiving = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    sample();
    got = {ce_rx, cfg_channel_enable, cfg_lsb_first, cfg_parity_type, cfg_busy,
           rd_valid, fifo_level, rd_data, overrun, drop_cnt};
    tests++;
    if (got !== RESET_VEC) begin
      fails++;
      $display("FAIL reset_outputs: got %07h want %07h", got, RESET_VEC);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      sample();
      if (ce_rx) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL reset_ce_quiet: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_cfg_idle();
    logic busy_seen;
    busy_seen = 1'b0;
    tick();
    write_cfg(8, 1'b0, 2'd2, 1'b1);
    sample();
    busy_seen |= cfg_busy;
    tick();
    cfg_wr = 1'b0;
    sample();
    busy_seen |= cfg_busy;
    tick();
    sample();
    busy_seen |= cfg_busy;
    tests++;
    if ({cfg_channel_enable, cfg_parity_type, cfg_lsb_first} !== {1'b1, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL cfg_idle_apply: got en=%0b par=%0d lsb=%0b want en=1 par=2 lsb=0",
               cfg_channel_enable, cfg_parity_type, cfg_lsb_first);
    end
    repeat (3) begin
      tick();
      sample();
      busy_seen |= cfg_busy;
    end
    tests++;
    if (busy_seen !== 1'b0) begin
      fails++;
      $display("FAIL cfg_idle_busy: got busy seen=%0b want 0", busy_seen);
    end
  endtask

  task automatic test_baud();
    for (int k = 0; k < 80; k++) begin
      tick();
      if (k == 0) is_receiving = 1'b1;
      sample();
      tests++;
      if (ce_rx !== ce_expected(k, 8)) begin
        fails++;
        $display("FAIL baud_div8 k=%0d: got %0b want %0b", k, ce_rx, ce_expected(k, 8));
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) is_receiving = 1'b0;
      sample();
      tests++;
      if (ce_rx !== 1'b0) begin
        fails++;
        $display("FAIL baud_after_frame k=%0d: got %0b want 0", k, ce_rx);
      end
    end
  endtask

  task automatic test_cfg_mid_frame();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 0) is_receiving = 1'b1;
      if (k == 6) write_cfg(12, 1'b1, 2'd0, 1'b0);
      if (k == 7) write_cfg(20, 1'b1, 2'd1, 1'b1);
      if (k == 8) cfg_wr = 1'b0;
      sample();
      tests++;
      if (ce_rx !== ce_expected(k, 8)) begin
        fails++;
        $display("FAIL midcfg_spacing k=%0d: got %0b want %0b", k, ce_rx, ce_expected(k, 8));
      end
      if (k >= 7) begin
        tests++;
        if ({cfg_busy, cfg_channel_enable, cfg_parity_type, cfg_lsb_first} !== {1'b1, 1'b1, 2'd2, 1'b0}) begin
          fails++;
          $display("FAIL midcfg_hold k=%0d: got busy=%0b en=%0b par=%0d lsb=%0b want busy=1 en=1 par=2 lsb=0",
                   k, cfg_busy, cfg_channel_enable, cfg_parity_type, cfg_lsb_first);
        end
      end
    end
    tick();
    is_receiving = 1'b0;
    sample();
    tests++;
    if ({cfg_busy, ce_rx} !== 2'b00) begin
      fails++;
      $display("FAIL midcfg_fall: got busy=%0b ce=%0b want 0 0", cfg_busy, ce_rx);
    end
    for (int k = 0; k < 35; k++) begin
      tick();
      if (k == 0) is_receiving = 1'b1;
      sample();
      if (k == 0) begin
        tests++;
        if ({cfg_busy, cfg_channel_enable, cfg_parity_type, cfg_lsb_first} !== {1'b0, 1'b1, 2'd1, 1'b1}) begin
          fails++;
          $display("FAIL midcfg_applied: got busy=%0b en=%0b par=%0d lsb=%0b want busy=0 en=1 par=1 lsb=1",
                   cfg_busy, cfg_channel_enable, cfg_parity_type, cfg_lsb_first);
        end
      end
      tests++;
      if (ce_rx !== ce_expected(k, 20)) begin
        fails++;
        $display("FAIL midcfg_div20 k=%0d: got %0b want %0b", k, ce_rx, ce_expected(k, 20));
      end
    end
    tick();
    is_receiving = 1'b0;
  endtask

  task automatic test_random_baud();
    int divs[5];
    divs = '{1, 0, 5, 4 + $urandom_range(0, 20), 4 + $urandom_range(0, 20)};
    foreach (divs[i]) begin
      int eff;
      int len;
      eff = (divs[i] < 4) ? 4 : divs[i];
      len = eff + $urandom_range(0, 2 * eff + 5);
      tick();
      write_cfg(divs[i], $urandom_range(0, 1), 2'($urandom_range(0, 2)), 1'b1);
      tick();
      cfg_wr = 1'b0;
      for (int k = 0; k < len + 4; k++) begin
        tick();
        is_receiving = (k < len);
        sample();
        tests++;
        if (ce_rx !== ((k < len) ? ce_expected(k, eff) : 1'b0)) begin
          fails++;
          $display("FAIL rand_baud div=%0d len=%0d k=%0d: got %0b want %0b", divs[i], len, k,
                   ce_rx, (k < len) ? ce_expected(k, eff) : 1'b0);
        end
      end
    end
  endtask

  task automatic test_fifo_overrun();
    for (int i = 1; i <= 9; i++) begin
      tick();
      received = 1'b1;
      rx_byte  = 8'(i);
    end
    tick();
    received = 1'b0;
    sample();
    tests++;
    if ({fifo_level, overrun, drop_cnt, rd_valid} !== {4'd8, 1'b1, 8'd1, 1'b1}) begin
      fails++;
      $display("FAIL ovr_full: got level=%0d ovr=%0b drop=%0d valid=%0b want 8 1 1 1",
               fifo_level, overrun, drop_cnt, rd_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      rd_en = 1'b1;
      sample();
      tests++;
      if (rd_data !== 8'(i)) begin
        fails++;
        $display("FAIL ovr_read %0d: got %02h want %02h", i, rd_data, 8'(i));
      end
    end
    tick();
    rd_en = 1'b0;
    sample();
    tests++;
    if ({rd_valid, fifo_level, rd_data} !== {1'b0, 4'd0, 8'd0}) begin
      fails++;
      $display("FAIL ovr_drained: got valid=%0b level=%0d data=%02h want 0 0 00", rd_valid, fifo_level, rd_data);
    end
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    sample();
    tests++;
    if ({overrun, drop_cnt} !== {1'b0, 8'd0}) begin
      fails++;
      $display("FAIL ovr_clear: got ovr=%0b drop=%0d want 0 0", overrun, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] q[$];
    logic [7:0] extra;
    for (int i = 0; i < 8; i++) begin
      tick();
      received = 1'b1;
      rx_byte  = 8'($urandom);
      q.push_back(rx_byte);
    end
    extra = 8'($urandom);
    tick();
    rx_byte = extra;
    rd_en   = 1'b1;
    sample();
    tests++;
    if (rd_data !== q[0]) begin
      fails++;
      $display("FAIL fullpp_head: got %02h want %02h", rd_data, q[0]);
    end
    void'(q.pop_front());
    q.push_back(extra);
    tick();
    received = 1'b0;
    rd_en    = 1'b0;
    sample();
    tests++;
    if ({fifo_level, overrun, drop_cnt} !== {4'd8, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL fullpp_level: got level=%0d ovr=%0b drop=%0d want 8 0 0", fifo_level, overrun, drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      rd_en = 1'b1;
      sample();
      tests++;
      if (rd_data !== q[i]) begin
        fails++;
        $display("FAIL fullpp_order %0d: got %02h want %02h", i, rd_data, q[i]);
      end
    end
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_clr_vs_drop();
    for (int i = 0; i < 8; i++) begin
      tick();
      received = 1'b1;
      rx_byte  = 8'($urandom);
    end
    tick();
    ovr_clr = 1'b1;
    tick();
    received = 1'b0;
    ovr_clr  = 1'b0;
    sample();
    tests++;
    if ({overrun, drop_cnt} !== {1'b1, 8'd1}) begin
      fails++;
      $display("FAIL clr_vs_drop: got ovr=%0b drop=%0d want 1 1", overrun, drop_cnt);
    end
  endtask

  task automatic test_drop_saturate();
    tick();
    received = 1'b1;
    repeat (259) tick();
    received = 1'b0;
    sample();
    tests++;
    if ({overrun, drop_cnt, fifo_level} !== {1'b1, 8'd255, 4'd8}) begin
      fails++;
      $display("FAIL drop_saturate: got ovr=%0b drop=%0d level=%0d want 1 255 8", overrun, drop_cnt, fifo_level);
    end
    tick();
    ovr_clr = 1'b1;
    rd_en   = 1'b1;
    repeat (8) tick();
    clear_inputs();
    sample();
    tests++;
    if ({overrun, drop_cnt, fifo_level} !== {1'b0, 8'd0, 4'd0}) begin
      fails++;
      $display("FAIL drop_cleared: got ovr=%0b drop=%0d level=%0d want 0 0 0", overrun, drop_cnt, fifo_level);
    end
  endtask

  task automatic test_random_fifo();
    logic [7:0] q[$];
    bit         m_ovr;
    int         m_drop;
    logic [21:0] got;
    logic [21:0] want;
    bit         full;
    m_ovr  = 1'b0;
    m_drop = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      received = 1'($urandom_range(0, 1));
      rx_byte  = 8'($urandom);
      rd_en    = ($urandom_range(0, 99) < 40);
      ovr_clr  = ($urandom_range(0, 99) < 4);
      sample();
      got  = {rd_valid, fifo_level, rd_data, overrun, drop_cnt};
      want = {q.size() != 0, 4'(q.size()), (q.size() != 0) ? q[0] : 8'h00, m_ovr, 8'(m_drop)};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL rand_fifo c=%0d: got %06h want %06h", c, got, want);
      end
      full = (q.size() == 8);
      if (received && full && !rd_en) begin
        m_ovr  = 1'b1;
        m_drop = ovr_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (ovr_clr) begin
        m_ovr  = 1'b0;
        m_drop = 0;
      end
      if (rd_en && q.size() != 0) void'(q.pop_front());
      if (received && (!full || rd_en)) q.push_back(rx_byte);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_frame();
    logic [27:0] got;
    tick();
    write_cfg(8, 1'b0, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      cfg_wr   = 1'b0;
      received = 1'b1;
      rx_byte  = 8'($urandom);
    end
    tick();
    received = 1'b0;
    rd_en    = 1'b1;
    repeat (8) tick();
    rd_en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      received = 1'b1;
      rx_byte  = 8'($urandom);
    end
    tick();
    received = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0) is_receiving = 1'b1;
    end
    sample();
    tests++;
    if (ce_rx !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_pulse: got %0b want 1", ce_rx);
    end
    rst_n = 1'b0;
    #1;
    got = {ce_rx, cfg_channel_enable, cfg_lsb_first, cfg_parity_type, cfg_busy,
           rd_valid, fifo_level, rd_data, overrun, drop_cnt};
    tests++;
    if (got !== RESET_VEC) begin
      fails++;
      $display("FAIL rst_mid_frame: got %07h want %07h", got, RESET_VEC);
    end
    tick();
    is_receiving = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 0) is_receiving = 1'b1;
      sample();
      tests++;
      if (ce_rx !== ce_expected(k, 16)) begin
        fails++;
        $display("FAIL rst_default_div k=%0d: got %0b want %0b", k, ce_rx, ce_expected(k, 16));
      end
    end
    tick();
    is_receiving = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_idle();
    test_baud();
    test_cfg_mid_frame();
    test_random_baud();
    test_fifo_overrun();
    test_full_push_pop();
    test_clr_vs_drop();
    test_drop_saturate();
    test_random_fifo();
    test_reset_mid_frame();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
